seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 99 +++++++++
 tb/tb_seq_detector_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised Moore serial-pattern detector (KMP transitions built at elaboration)
// Optional 8-bit saturating match counter and match_cnt port when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 OVERLAP = 1,
  localparam int                SW      = $clog2(PAT_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w,
  input  logic          en,
  input  logic          clr,
  output logic          z,
  output logic [SW-1:0] cs,
  output logic [SW-1:0] ns
`ifdef SEQDET_COUNT_EN
  ,
  output logic [7:0]    match_cnt
`endif
);

  // Pattern bit i counted from the MSB (the first bit received).
  function automatic int pat_bit(input int i);
    return int'(PATTERN[PAT_LEN-1-i]);
  endfunction

  // Bit j of (first k pattern bits followed by b).
  function automatic int seq_bit(input int k, input int b, input int j);
    return (j < k) ? pat_bit(j) : b;
  endfunction

  function automatic int kmp_next(input int k, input int b);
    int  best;
    bit  ok;
    if (k == PAT_LEN && OVERLAP == 0)
      return (b == pat_bit(0)) ? 1 : 0;
    best = 0;
    for (int len = 1; len <= PAT_LEN; len++) begin
      if (len <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < len; i++)
          if (seq_bit(k, b, k + 1 - len + i) != pat_bit(i)) ok = 1'b0;
        if (ok) best = len;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] w_nxt0 [PAT_LEN+1];
  logic [SW-1:0] w_nxt1 [PAT_LEN+1];

  for (genvar k = 0; k <= PAT_LEN; k++) begin : g_tbl
    localparam logic [SW-1:0] N0 = SW'(kmp_next(k, 0));
    localparam logic [SW-1:0] N1 = SW'(kmp_next(k, 1));
    assign w_nxt0[k] = N0;
    assign w_nxt1[k] = N1;
  end

  logic [SW-1:0] r_cs;
  logic [SW-1:0] w_ns;

  // Encodings above PAT_LEN are unreachable; an enabled edge recovers them to 0.
  always_comb begin
    w_ns = en ? '0 : r_cs;
    if (en) begin
      for (int k = 0; k <= PAT_LEN; k++)
        if (r_cs == SW'(k)) w_ns = w ? w_nxt1[k] : w_nxt0[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cs <= '0;
    else      r_cs <= w_ns;
  end

  assign cs = r_cs;
  assign ns = w_ns;
  assign z  = (r_cs == SW'(PAT_LEN));

`ifdef SEQDET_COUNT_EN
  logic [7:0] r_match_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_match_cnt <= '0;
    else if (clr)
      r_match_cnt <= '0;
    else if (en && w_ns == SW'(PAT_LEN) && r_match_cnt != 8'hFF)
      r_match_cnt <= r_match_cnt + 8'd1;
  end

  assign match_cnt = r_match_cnt;
`else
  logic w_unused;
  assign w_unused = clr;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench: three detector configurations against a prefix/suffix history model
// Counter checks are compiled in only when SEQDET_COUNT_EN is defined.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic w   = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] cs_a [3];
  logic [2:0] ns_a [3];
  logic       z_a  [3];
  logic [7:0] mc_a [3];

  seq_detector_param u_ovl (
    .clk(clk), .rst(rst), .w(w), .en(en), .clr(clr),
    .z(z_a[0]), .cs(cs_a[0]), .ns(ns_a[0])
`ifdef SEQDET_COUNT_EN
    , .match_cnt(mc_a[0])
`endif
  );

  seq_detector_param #(.OVERLAP(0)) u_non (
    .clk(clk), .rst(rst), .w(w), .en(en), .clr(clr),
    .z(z_a[1]), .cs(cs_a[1]), .ns(ns_a[1])
`ifdef SEQDET_COUNT_EN
    , .match_cnt(mc_a[1])
`endif
  );

  seq_detector_param #(.PAT_LEN(6), .PATTERN(6'b110110), .OVERLAP(1)) u_six (
    .clk(clk), .rst(rst), .w(w), .en(en), .clr(clr),
    .z(z_a[2]), .cs(cs_a[2]), .ns(ns_a[2])
`ifdef SEQDET_COUNT_EN
    , .match_cnt(mc_a[2])
`endif
  );

  int          plen [3] = '{4, 4, 6};
  logic [31:0] pat  [3] = '{32'b1011, 32'b1011, 32'b110110};
  int          ovl  [3] = '{1, 0, 1};
  logic [31:0] mh   [3];
  int          mlen [3];
  int          mst  [3];
  int          mcnt [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Longest pattern prefix that is a suffix of the sampled history.
  function automatic int prefix_state(input logic [31:0] h, input int hl, input int pl, input logic [31:0] pt);
    bit ok;
    for (int k = (hl < pl ? hl : pl); k >= 1; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (h[k-1-i] != pt[pl-1-i]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  function automatic int next_state(input int d, input logic iw, input logic ien);
    if (!ien) return mst[d];
    if (ovl[d] == 0 && mst[d] == plen[d])
      return prefix_state({31'd0, iw}, 1, plen[d], pat[d]);
    return prefix_state({mh[d][30:0], iw}, (mlen[d] < 8 ? mlen[d] + 1 : 8), plen[d], pat[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mh[d] = '0; mlen[d] = 0; mst[d] = 0; mcnt[d] = 0;
    end
  endtask

  task automatic model_update(input logic iw, input logic ien, input logic iclr);
    for (int d = 0; d < 3; d++) begin
      if (ien) begin
        if (ovl[d] == 0 && mst[d] == plen[d]) begin
          mh[d] = {31'd0, iw}; mlen[d] = 1;
        end else begin
          mh[d] = {mh[d][30:0], iw}; mlen[d] = (mlen[d] < 8) ? mlen[d] + 1 : 8;
        end
        mst[d] = prefix_state(mh[d], mlen[d], plen[d], pat[d]);
        if (mst[d] == plen[d] && mcnt[d] < 255) mcnt[d]++;
      end
      if (iclr) mcnt[d] = 0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("cs[%0d]", d), 32'(cs_a[d]), 32'(mst[d]));
      check_eq($sformatf("z[%0d]", d), 32'(z_a[d]), 32'(mst[d] == plen[d]));
`ifdef SEQDET_COUNT_EN
      check_eq($sformatf("cnt[%0d]", d), 32'(mc_a[d]), 32'(mcnt[d]));
`endif
    end
  endtask

  task automatic step(input logic iw, input logic ien, input logic iclr);
    @(negedge clk);
    w = iw; en = ien; clr = iclr;
    #1;
    for (int d = 0; d < 3; d++)
      check_eq($sformatf("ns[%0d]", d), 32'(ns_a[d]), 32'(next_state(d, iw, ien)));
    @(posedge clk);
    #1;
    if (rst) model_update(iw, ien, iclr);
    check_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [6:0] seq_a   = 7'b1011011;
  int         exp_a0 [7] = '{1, 2, 3, 4, 2, 3, 4};
  int         exp_a1 [7] = '{1, 2, 3, 4, 0, 1, 1};
  logic [8:0] seq_b   = 9'b110110110;
  logic [3:0] seq_c   = 4'b1011;

  initial begin
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      step(seq_a[6-i], 1'b1, 1'b0);
      check_eq($sformatf("ovl_cs_e%0d", i + 1), 32'(cs_a[0]), 32'(exp_a0[i]));
      check_eq($sformatf("non_cs_e%0d", i + 1), 32'(cs_a[1]), 32'(exp_a1[i]));
    end
`ifdef SEQDET_COUNT_EN
    check_eq("ovl_cnt_a", 32'(mc_a[0]), 32'd2);
    check_eq("non_cnt_a", 32'(mc_a[1]), 32'd1);
`endif

    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      check_eq("hold_cs", 32'(cs_a[0]), 32'd4);
      check_eq("hold_z", 32'(z_a[0]), 32'd1);
`ifdef SEQDET_COUNT_EN
      check_eq("hold_cnt", 32'(mc_a[0]), 32'd2);
`endif
    end

    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_eq("pre_rst_cs", 32'(cs_a[0]), 32'd3);
    async_reset();
    for (int i = 0; i < 4; i++) begin
      step(seq_c[3-i], 1'b1, 1'b0);
      check_eq($sformatf("post_rst_z_e%0d", i + 1), 32'(z_a[0]), 32'(i == 3));
    end

    async_reset();
    for (int i = 0; i < 9; i++) begin
      step(seq_b[8-i], 1'b1, 1'b0);
      check_eq($sformatf("six_z_e%0d", i + 1), 32'(z_a[2]), 32'(i == 5 || i == 8));
    end

    async_reset();
    for (int r = 0; r < 300; r++)
      for (int i = 0; i < 4; i++) step(seq_c[3-i], 1'b1, 1'b0);
`ifdef SEQDET_COUNT_EN
    check_eq("sat_cnt", 32'(mc_a[0]), 32'd255);
`endif
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_eq("clr_cs", 32'(cs_a[0]), 32'd4);
`ifdef SEQDET_COUNT_EN
    check_eq("clr_cnt", 32'(mc_a[0]), 32'd0);
`endif

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8), ($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
